// File: rtl/nmea_header_matcher.sv
// nmea_header_matcher
// Compares an incoming byte stream against N fixed-length reference headers
// in parallel. Each channel keeps its own match position and falls back by a
// single byte on a mismatch, so a repeated start byte ("$$GPZDA") still hits.
// A reference byte equal to WILD matches any data byte. Every output is
// registered and follows the loaded byte by one clock.

module nmea_header_matcher #(
   parameter int               B    = 8,
   parameter int               L    = 6,
   parameter int               N    = 4,
   parameter logic [N*L*B-1:0] REFS = {"$GPZDA", "$GPRMC", "$GPGGA", "$GPGSV"},
   parameter logic [B-1:0]     WILD = "?",
   parameter int               IW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          restart,
   input  logic [N-1:0]  enable,
   input  logic          load,
   input  logic [B-1:0]  data,
   output logic [N-1:0]  hit,
   output logic          hit_valid,
   output logic [IW-1:0] hit_id,
   output logic          busy,
   output logic          reject
);

   localparam int CW = $clog2(L + 1);

   logic [N-1:0]  hit_next;
   logic [N-1:0]  active_next;
   logic [IW-1:0] hit_id_next;
   logic          reject_next;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_ch
         logic [CW-1:0] cnt_reg;
         logic [CW-1:0] cnt_next;
         logic [CW-1:0] p;
         logic [L-1:0]  match_vec;
         logic          match_p;
         logic          hit_c;

         // Byte 0 is the first transmitted byte and sits in the MSB slot.
         genvar gk;
         for (gk = 0; gk < L; gk++) begin : g_byte
            localparam logic [B-1:0] REF_BYTE = REFS[gi*L*B + (L-1-gk)*B +: B];
            assign match_vec[gk] = (REF_BYTE == WILD) || (REF_BYTE == data);
         end

         // Next position and hit for this channel; restart drops prior progress
         // but the same-cycle byte is still evaluated from position 0.
         always_comb begin
            p       = restart ? '0 : cnt_reg;
            match_p = 1'b0;
            for (int k = 0; k < L; k++) begin
               if (p == CW'(k)) match_p = match_vec[k];
            end
            cnt_next = p;
            hit_c    = 1'b0;
            if (!enable[gi]) begin
               cnt_next = '0;
            end else if (load) begin
               if (match_p) begin
                  if (p == CW'(L - 1)) begin
                     hit_c    = 1'b1;
                     cnt_next = '0;
                  end else begin
                     cnt_next = p + CW'(1);
                  end
               end else begin
                  // Single-byte re-sync: the failing byte may itself start a header.
                  cnt_next = match_vec[0] ? CW'(1) : '0;
               end
            end
         end

         // Channel position register.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) cnt_reg <= '0;
            else          cnt_reg <= cnt_next;
         end

         // Disabled channels are already forced to zero, so a non-zero count
         // implies the channel is enabled.
         assign hit_next[gi]    = hit_c;
         assign active_next[gi] = |cnt_next;
      end
   endgenerate

   // Lowest hitting channel wins; the index holds when nothing hits.
   always_comb begin
      hit_id_next = hit_id;
      for (int c = N - 1; c >= 0; c--) begin
         if (hit_next[c]) hit_id_next = IW'(c);
      end
   end

   assign reject_next = load && !(|hit_next) && !(|active_next);

   // Registered status outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hit       <= '0;
         hit_valid <= 1'b0;
         hit_id    <= '0;
         busy      <= 1'b0;
         reject    <= 1'b0;
      end else begin
         hit       <= hit_next;
         hit_valid <= |hit_next;
         hit_id    <= hit_id_next;
         busy      <= |active_next;
         reject    <= reject_next;
      end
   end

endmodule
